// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad row scanner: synchronizes columns, debounces press/release, and holds
// one one-hot {row, col} code behind a valid/ack register. Auto-repeat is built only with KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int SETTLE_CYCLES   = 16,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int REPEAT_DELAY    = 500000,
   parameter int REPEAT_RATE     = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_row,
   output logic [3:0] key_col,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       overrun,
   output logic       key_down
);

   if (SETTLE_CYCLES < 3 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
      $error("keypad_scanner: parameter out of range");
   end

   localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   // Handshake: key_valid high means key_row/key_col hold an unread code; a key_ack pulse
   // while valid consumes it at the next edge. A push in the same cycle as key_ack is accepted.
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    idx, idx_n;
   logic [3:0]    row_n, cand_col, cand_n;
   logic [3:0]    col_m, col_s;
   logic [3:0]    kr_n, kc_n;
   logic          kv_n, ov_n, down_n;
   logic          push, rep_push, advance;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_m     <= '0;
         col_s     <= '0;
         state     <= SCAN;
         cnt       <= '0;
         idx       <= '0;
         row_out   <= 4'b0001;
         cand_col  <= '0;
         key_row   <= '0;
         key_col   <= '0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
         key_down  <= 1'b0;
      end else begin
         col_m     <= col_in;
         col_s     <= col_m;
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         row_out   <= row_n;
         cand_col  <= cand_n;
         key_row   <= kr_n;
         key_col   <= kc_n;
         key_valid <= kv_n;
         overrun   <= ov_n;
         key_down  <= down_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      row_n   = row_out;
      cand_n  = cand_col;
      down_n  = key_down;
      push    = 1'b0;
      advance = 1'b0;
      case (state)
         SCAN: begin
            if (cnt == SETTLE_LAST) begin
               cnt_n = '0;
               // Zero or multi-bit columns (ghosting) are ignored; move on to the next row.
               if ($onehot(col_s)) begin
                  cand_n  = col_s;
                  state_n = DEBOUNCE;
               end else begin
                  advance = 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (col_s != cand_col) begin
               cnt_n   = '0;
               state_n = SCAN;
               advance = 1'b1;
            end else if (cnt == DEB_LAST) begin
               cnt_n   = '0;
               state_n = HELD;
               push    = 1'b1;
               down_n  = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         HELD: begin
            if (col_s != 4'b0000) begin
               cnt_n = '0;
            end else if (cnt == DEB_LAST) begin
               cnt_n   = '0;
               state_n = SCAN;
               advance = 1'b1;
               down_n  = 1'b0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = SCAN;
            cnt_n   = '0;
         end
      endcase
      if (advance) begin
         idx_n = idx + 2'd1;
         row_n = 4'b0001 << idx_n;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
   localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

   logic [RW-1:0] rep_cnt, rep_cnt_n;
   logic          rep_rate, rep_rate_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt  <= '0;
         rep_rate <= 1'b0;
      end else begin
         rep_cnt  <= rep_cnt_n;
         rep_rate <= rep_rate_n;
      end
   end

   // Counter idles at zero outside HELD; any zero column cycle restarts the delay phase.
   always_comb begin
      rep_cnt_n  = '0;
      rep_rate_n = 1'b0;
      rep_push   = 1'b0;
      if (state == HELD && col_s != 4'b0000) begin
         if ((!rep_rate && rep_cnt == DELAY_LAST) || (rep_rate && rep_cnt == RATE_LAST)) begin
            rep_push   = 1'b1;
            rep_rate_n = 1'b1;
         end else begin
            rep_cnt_n  = rep_cnt + 1'b1;
            rep_rate_n = rep_rate;
         end
      end
   end
`else
   assign rep_push = 1'b0;
`endif

   // row_out is frozen outside SCAN, so it is the candidate row for every push.
   always_comb begin
      kv_n = key_valid;
      ov_n = overrun;
      kr_n = key_row;
      kc_n = key_col;
      if (key_ack) begin
         kv_n = 1'b0;
         ov_n = 1'b0;
      end
      if (push || rep_push) begin
         if (!key_valid || key_ack) begin
            kr_n = row_out;
            kc_n = cand_col;
            kv_n = 1'b1;
         end else begin
            ov_n = 1'b1;
         end
      end
   end

endmodule
